// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared branch-kind and fetch FSM encodings for the MIPS core.
package cpu_pkg;

  typedef enum logic [3:0] {
    B_BNE    = 4'd0,
    B_BEQ    = 4'd1,
    B_BGEZ   = 4'd2,
    B_BGTZ   = 4'd3,
    B_BLEZ   = 4'd4,
    B_BLTZ   = 4'd5,
    B_BLTZAL = 4'd6,
    B_BGEZAL = 4'd7
  } b_type_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/branch_resolve.sv
// rtl/branch_resolve.sv - combinational taken flag, target and delay-slot PC for decode's branch/jump.
module branch_resolve
  import cpu_pkg::*;
#(
  parameter int AW = 32
) (
  input  logic [AW-1:0] pc_i,
  input  logic          is_b_i,
  input  logic          is_j_i,
  input  logic          is_jr_i,
  input  logic [3:0]    b_type_i,
  input  logic [15:0]   b_offset_i,
  input  logic [25:0]   j_index_i,
  input  logic [AW-1:0] rs_i,
  input  logic [AW-1:0] rt_i,
  output logic          taken_o,
  output logic [AW-1:0] target_o,
  output logic [AW-1:0] ds_pc_o
);

  logic [AW-1:0] pc4;
  logic          cond;

  assign pc4     = pc_i + AW'(4);
  assign ds_pc_o = pc4;

  always_comb begin
    cond = 1'b0;
    case (b_type_i)
      B_BNE:              cond = (rs_i != rt_i);
      B_BEQ:              cond = (rs_i == rt_i);
      B_BGEZ, B_BGEZAL:   cond = ($signed(rs_i) >= 0);
      B_BGTZ:             cond = ($signed(rs_i) > 0);
      B_BLEZ:             cond = ($signed(rs_i) <= 0);
      B_BLTZ, B_BLTZAL:   cond = ($signed(rs_i) < 0);
      default:            cond = 1'b0;
    endcase
  end

  assign taken_o = (is_b_i & cond) | is_j_i | is_jr_i;

  always_comb begin
    if (is_jr_i)
      target_o = rs_i;
    else if (is_j_i)
      target_o = {pc4[AW-1:AW-4], j_index_i, 2'b00};
    else
      target_o = pc4 + {{(AW-18){b_offset_i[15]}}, b_offset_i, 2'b00};
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - fetch-stage PC engine: redirects, delay slots, one-outstanding
// SRAM-like instruction port and a valid/ready slot towards decode.
module pc_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR = 32'hbfc00000,
  parameter logic [31:0] EXC_ADDR   = 32'hbfc00380,
  parameter int          AW         = 32
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          de_valid,
  input  logic [AW-1:0] de_pc,
  input  logic          is_b,
  input  logic          is_j,
  input  logic          is_jr,
  input  logic [3:0]    b_type,
  input  logic [15:0]   b_offset,
  input  logic [25:0]   j_index,
  input  logic [AW-1:0] de_rs_data,
  input  logic [AW-1:0] de_rt_data,
  input  logic          exc_valid,
  input  logic          eret_valid,
  input  logic [AW-1:0] epc,
  output logic          inst_req,
  output logic [AW-1:0] inst_addr,
  input  logic          inst_addr_ok,
  input  logic          inst_data_ok,
  input  logic [AW-1:0] inst_rdata,
  output logic          fs_valid,
  output logic [AW-1:0] fs_pc,
  output logic [AW-1:0] fs_inst,
  input  logic          fs_ready
);

  fetch_state_e  state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic          cancel_q, cancel_d;
  logic          pend_valid_q, pend_valid_d;
  logic [AW-1:0] pend_target_q, pend_target_d;
  logic [AW-1:0] pend_ds_q, pend_ds_d;
  logic          pend_ds_ok_q, pend_ds_ok_d;
  logic [AW-1:0] buf_pc_q, buf_pc_d;
  logic [AW-1:0] buf_inst_q, buf_inst_d;
  logic          fs_valid_q, fs_valid_d;
  logic [AW-1:0] fs_pc_q, fs_pc_d;
  logic [AW-1:0] fs_inst_q, fs_inst_d;

  logic          br_taken;
  logic [AW-1:0] br_target;
  logic [AW-1:0] br_ds;

  branch_resolve #(.AW(AW)) u_branch_resolve (
    .pc_i       (de_pc),
    .is_b_i     (is_b),
    .is_j_i     (is_j),
    .is_jr_i    (is_jr),
    .b_type_i   (b_type),
    .b_offset_i (b_offset),
    .j_index_i  (j_index),
    .rs_i       (de_rs_data),
    .rt_i       (de_rt_data),
    .taken_o    (br_taken),
    .target_o   (br_target),
    .ds_pc_o    (br_ds)
  );

  // Effective pending redirect this cycle: a fresh redirect overrides the registered one.
  // pv_ds_ok says whether the word at pv_ds may still be kept as a delay slot.
  logic          redirect;
  logic          pv;
  logic [AW-1:0] pv_target;
  logic [AW-1:0] pv_ds;
  logic          pv_ds_ok;
  logic          wrong_cur;
  logic          wrong_buf;

  always_comb begin
    redirect  = exc_valid | eret_valid;
    pv        = pend_valid_q;
    pv_target = pend_target_q;
    pv_ds     = pend_ds_q;
    pv_ds_ok  = pend_ds_ok_q;
    if (exc_valid) begin
      pv        = 1'b1;
      pv_target = EXC_ADDR;
      pv_ds_ok  = 1'b0;
    end else if (eret_valid) begin
      pv        = 1'b1;
      pv_target = epc;
      pv_ds_ok  = 1'b0;
    end else if (de_valid && br_taken) begin
      pv        = 1'b1;
      pv_target = br_target;
      pv_ds     = br_ds;
      pv_ds_ok  = 1'b1;
    end
    wrong_cur = pv & ~(pv_ds_ok & (pc_q == pv_ds));
    wrong_buf = pv & ~(pv_ds_ok & (buf_pc_q == pv_ds));
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    cancel_d      = cancel_q;
    pend_valid_d  = pv;
    pend_target_d = pv_target;
    pend_ds_d     = pv_ds;
    pend_ds_ok_d  = pv_ds_ok;
    buf_pc_d      = buf_pc_q;
    buf_inst_d    = buf_inst_q;
    fs_valid_d    = fs_valid_q & ~fs_ready;
    fs_pc_d       = fs_pc_q;
    fs_inst_d     = fs_inst_q;

    case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
        if (pv) begin
          pc_d         = pv_target;
          pend_valid_d = 1'b0;
        end
      end
      S_REQ: begin
        // inst_addr is held until accepted; a wrong-path acceptance is cancelled on return.
        if (inst_addr_ok) begin
          state_d = S_WAIT;
          if (wrong_cur) begin
            cancel_d     = 1'b1;
            pc_d         = pv_target;
            pend_valid_d = 1'b0;
          end
        end
      end
      S_WAIT: begin
        if (inst_data_ok) begin
          state_d  = S_REQ;
          cancel_d = 1'b0;
          if (cancel_q || wrong_cur) begin
            if (pv) pc_d = pv_target;
            pend_valid_d = 1'b0;
          end else begin
            pc_d         = pv ? pv_target : pc_q + AW'(4);
            pend_valid_d = 1'b0;
            if (!fs_valid_q || fs_ready) begin
              fs_valid_d = 1'b1;
              fs_pc_d    = pc_q;
              fs_inst_d  = inst_rdata;
            end else begin
              buf_pc_d   = pc_q;
              buf_inst_d = inst_rdata;
              state_d    = S_HOLD;
            end
          end
        end else if (wrong_cur) begin
          cancel_d     = 1'b1;
          pc_d         = pv_target;
          pend_valid_d = 1'b0;
        end
      end
      S_HOLD: begin
        if (pv) begin
          pc_d         = pv_target;
          pend_valid_d = 1'b0;
        end
        if (wrong_buf) begin
          state_d = S_REQ;
        end else if (fs_ready) begin
          fs_valid_d = 1'b1;
          fs_pc_d    = buf_pc_q;
          fs_inst_d  = buf_inst_q;
          state_d    = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (redirect) fs_valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_ADDR;
      cancel_q      <= 1'b0;
      pend_valid_q  <= 1'b0;
      pend_target_q <= '0;
      pend_ds_q     <= '0;
      pend_ds_ok_q  <= 1'b0;
      buf_pc_q      <= '0;
      buf_inst_q    <= '0;
      fs_valid_q    <= 1'b0;
      fs_pc_q       <= '0;
      fs_inst_q     <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      cancel_q      <= cancel_d;
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
      pend_ds_q     <= pend_ds_d;
      pend_ds_ok_q  <= pend_ds_ok_d;
      buf_pc_q      <= buf_pc_d;
      buf_inst_q    <= buf_inst_d;
      fs_valid_q    <= fs_valid_d;
      fs_pc_q       <= fs_pc_d;
      fs_inst_q     <= fs_inst_d;
    end
  end

  assign inst_req  = (state_q == S_REQ);
  assign inst_addr = pc_q;
  assign fs_valid  = fs_valid_q;
  assign fs_pc     = fs_pc_q;
  assign fs_inst   = fs_inst_q;

endmodule
